// File: rtl/udma_pkg.sv
// Shared definitions for the uDMA stream sink: datasize encoding, FSM states, byte increment.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package udma_pkg;

    localparam logic [1:0] DSIZE_1B  = 2'b00;
    localparam logic [1:0] DSIZE_2B  = 2'b01;
    localparam logic [1:0] DSIZE_4B  = 2'b10;
    localparam logic [1:0] DSIZE_ILL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_XFER  = 2'd2,
        ST_DRAIN = 2'd3
    } sink_state_t;

    // Bytes consumed by one beat; the illegal code advances like a 4-byte beat.
    function automatic logic [2:0] dsize_inc(input logic [1:0] ds);
        logic [2:0] inc;
        case (ds)
            DSIZE_1B: inc = 3'd1;
            DSIZE_2B: inc = 3'd2;
            default:  inc = 3'd4;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/udma_stream_sink_buf.sv
// Two-entry beat buffer between the stream bus and the L2 write port.
// Latency: a beat pushed in cycle N is visible at the pop side in cycle N+1.
// Backpressure: push_rdy drops when both entries are full; no pass-through when full.
// Ports: clk_i/rstn_i/clr_i; push_vld/push_rdy/push_dat; pop_vld/pop_rdy/pop_dat (head entry).
module udma_stream_sink_buf #(
    parameter int WIDTH = 36
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clr_i,
    input  logic             push_vld,
    output logic             push_rdy,
    input  logic [WIDTH-1:0] push_dat,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_idx;
    logic             rd_idx;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign push_rdy = (count != 2'd2);
    assign pop_vld  = (count != 2'd0);
    assign pop_dat  = mem[rd_idx];
    assign do_push  = push_vld & push_rdy;
    assign do_pop   = pop_vld & pop_rdy;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            count  <= 2'd0;
        end else if (clr_i) begin
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_idx <= ~wr_idx;
            if (do_pop)  rd_idx <= ~rd_idx;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) mem[wr_idx] <= push_dat;
    end

endmodule

// File: rtl/udma_stream_sink_unit.sv
// uDMA stream sink: accepts beats for INST_ID and writes them into a circular L2 buffer.
// Latency: beat accepted in cycle N raises rx_ch_req_o in N+1; events/pointer update one cycle after gnt.
// Backpressure: in_stream_ready_o low when buffer full, draining after EOT, idle, or dest mismatch.
// Ports: stream in (dest/data/datasize/valid/sot/eot/ready), rx-channel out (req/addr/datasize/data/gnt),
//        cfg (en/start/size), cmd_clr_i, status (wr_ptr_o, evt_eot_o, evt_wrap_o, sticky err_o).
module udma_stream_sink_unit
    import udma_pkg::*;
#(
    parameter int TRANS_SIZE     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int STREAM_ID_SIZE = 2,
    parameter int INST_ID        = 0
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      cmd_clr_i,
    input  logic                      cfg_en_i,
    input  logic [TRANS_SIZE-1:0]     cfg_start_addr_i,
    input  logic [TRANS_SIZE-1:0]     cfg_size_i,
    input  logic [STREAM_ID_SIZE-1:0] in_stream_dest_i,
    input  logic [DATA_WIDTH-1:0]     in_stream_data_i,
    input  logic [1:0]                in_stream_datasize_i,
    input  logic                      in_stream_valid_i,
    input  logic                      in_stream_sot_i,
    input  logic                      in_stream_eot_i,
    output logic                      in_stream_ready_o,
    output logic                      rx_ch_req_o,
    output logic [TRANS_SIZE-1:0]     rx_ch_addr_o,
    output logic [1:0]                rx_ch_datasize_o,
    output logic [DATA_WIDTH-1:0]     rx_ch_data_o,
    input  logic                      rx_ch_gnt_i,
    output logic [TRANS_SIZE-1:0]     wr_ptr_o,
    output logic                      evt_eot_o,
    output logic                      evt_wrap_o,
    output logic                      err_o
);

    localparam int BUF_W = DATA_WIDTH + 4;
    localparam logic [STREAM_ID_SIZE-1:0] MY_ID = INST_ID[STREAM_ID_SIZE-1:0];

    sink_state_t           state;
    logic [TRANS_SIZE-1:0] base_q;
    logic [TRANS_SIZE-1:0] size_q;
    logic [TRANS_SIZE-1:0] offset_q;

    logic                  match;
    logic                  ready;
    logic                  accept;
    logic                  buf_push_vld;
    logic                  buf_push_rdy;
    logic                  buf_pop_vld;
    logic [BUF_W-1:0]      buf_pop_dat;

    logic [DATA_WIDTH-1:0] head_data;
    logic [1:0]            head_ds;
    logic                  head_sot;
    logic                  head_eot;
    logic                  gnt_fire;
    logic [TRANS_SIZE-1:0] cur_base;
    logic [TRANS_SIZE-1:0] cur_size;
    logic [TRANS_SIZE-1:0] cur_ofs;
    logic [TRANS_SIZE:0]   next_sum;
    logic                  wrap_hit;

    assign match = (in_stream_dest_i == MY_ID);

    always_comb begin
        ready = 1'b0;
        case (state)
            ST_ARMED: ready = match & cfg_en_i & buf_push_rdy;
            ST_XFER:  ready = match & buf_push_rdy;
            default:  ready = 1'b0;
        endcase
    end

    assign in_stream_ready_o = ready;
    assign accept            = in_stream_valid_i & ready;
    // While armed, only an SOT beat opens a transfer; stray beats are dropped.
    assign buf_push_vld      = accept & ((state == ST_XFER) | in_stream_sot_i);

    udma_stream_sink_buf #(
        .WIDTH (BUF_W)
    ) u_buf (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clr_i    (cmd_clr_i),
        .push_vld (buf_push_vld),
        .push_rdy (buf_push_rdy),
        .push_dat ({in_stream_data_i, in_stream_datasize_i, in_stream_sot_i, in_stream_eot_i}),
        .pop_vld  (buf_pop_vld),
        .pop_rdy  (rx_ch_gnt_i),
        .pop_dat  (buf_pop_dat)
    );

    assign {head_data, head_ds, head_sot, head_eot} = buf_pop_dat;
    assign gnt_fire = buf_pop_vld & rx_ch_gnt_i;

    // An SOT beat starts a fresh window at its own write, even if earlier beats
    // of the previous transfer were still queued ahead of it.
    assign cur_base = head_sot ? cfg_start_addr_i : base_q;
    assign cur_size = head_sot ? cfg_size_i       : size_q;
    assign cur_ofs  = head_sot ? '0               : offset_q;
    assign next_sum = {1'b0, cur_ofs} + {{(TRANS_SIZE-2){1'b0}}, dsize_inc(head_ds)};
    assign wrap_hit = (cur_size != '0) && (next_sum >= {1'b0, cur_size});

    assign rx_ch_req_o      = buf_pop_vld;
    assign rx_ch_addr_o     = buf_pop_vld ? (cur_base + cur_ofs) : '0;
    assign rx_ch_datasize_o = buf_pop_vld ? head_ds : 2'b00;
    assign rx_ch_data_o     = buf_pop_vld ? head_data : '0;
    assign wr_ptr_o         = offset_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= ST_IDLE;
            base_q     <= '0;
            size_q     <= '0;
            offset_q   <= '0;
            evt_eot_o  <= 1'b0;
            evt_wrap_o <= 1'b0;
            err_o      <= 1'b0;
        end else if (cmd_clr_i) begin
            state      <= ST_IDLE;
            base_q     <= '0;
            size_q     <= '0;
            offset_q   <= '0;
            evt_eot_o  <= 1'b0;
            evt_wrap_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            evt_eot_o  <= 1'b0;
            evt_wrap_o <= 1'b0;

            if (gnt_fire) begin
                offset_q   <= wrap_hit ? '0 : next_sum[TRANS_SIZE-1:0];
                evt_wrap_o <= wrap_hit;
                evt_eot_o  <= head_eot;
                if (head_sot) begin
                    base_q <= cfg_start_addr_i;
                    size_q <= cfg_size_i;
                end
                if (head_ds == DSIZE_ILL) err_o <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cfg_en_i) state <= ST_ARMED;
                end
                ST_ARMED: begin
                    // Buffer is always empty here, so no write competes with these updates.
                    if (accept) begin
                        if (in_stream_sot_i) begin
                            base_q   <= cfg_start_addr_i;
                            size_q   <= cfg_size_i;
                            offset_q <= '0;
                            state    <= in_stream_eot_i ? ST_DRAIN : ST_XFER;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end else if (!cfg_en_i) begin
                        state <= ST_IDLE;
                    end
                end
                ST_XFER: begin
                    if (accept && in_stream_eot_i) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!buf_pop_vld) state <= cfg_en_i ? ST_ARMED : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udma_stream_sink_unit.sv
module tb_udma_stream_sink_unit;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_clr = 1'b0;
    logic        cfg_en = 1'b0;
    logic [15:0] cfg_start = '0;
    logic [15:0] cfg_size = '0;
    logic [1:0]  dest = '0;
    logic [31:0] sdata = '0;
    logic [1:0]  sds = '0;
    logic        svalid = 1'b0;
    logic        ssot = 1'b0;
    logic        seot = 1'b0;
    logic        gnt = 1'b1;
    logic        ready;
    logic        req;
    logic [15:0] addr;
    logic [1:0]  rds;
    logic [31:0] rdata;
    logic [15:0] wr_ptr;
    logic        evt_eot;
    logic        evt_wrap;
    logic        err;

    always #5 clk = ~clk;

    udma_stream_sink_unit #(
        .TRANS_SIZE     (16),
        .DATA_WIDTH     (32),
        .STREAM_ID_SIZE (2),
        .INST_ID        (0)
    ) dut (
        .clk_i                (clk),
        .rstn_i               (rstn),
        .cmd_clr_i            (cmd_clr),
        .cfg_en_i             (cfg_en),
        .cfg_start_addr_i     (cfg_start),
        .cfg_size_i           (cfg_size),
        .in_stream_dest_i     (dest),
        .in_stream_data_i     (sdata),
        .in_stream_datasize_i (sds),
        .in_stream_valid_i    (svalid),
        .in_stream_sot_i      (ssot),
        .in_stream_eot_i      (seot),
        .in_stream_ready_o    (ready),
        .rx_ch_req_o          (req),
        .rx_ch_addr_o         (addr),
        .rx_ch_datasize_o     (rds),
        .rx_ch_data_o         (rdata),
        .rx_ch_gnt_i          (gnt),
        .wr_ptr_o             (wr_ptr),
        .evt_eot_o            (evt_eot),
        .evt_wrap_o           (evt_wrap),
        .err_o                (err)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] data;
        logic [1:0]  ds;
        logic        sot;
        logic        eot;
        logic [15:0] base;
        logic [15:0] size;
    } beat_t;

    beat_t       q[$];
    beat_t       e;
    logic [15:0] m_ofs = '0;
    logic [15:0] m_base = '0;
    logic [15:0] m_size = '0;
    logic        m_wrap = 1'b0;
    logic        m_eot = 1'b0;
    logic        m_err = 1'b0;
    logic        m_open = 1'b0;
    logic        mon_en = 1'b0;
    logic [15:0] cur;
    logic [16:0] nxt;
    logic [15:0] addr_log[$];
    int          wrap_cnt = 0;
    int          eot_cnt = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("req_vs_pending", req, (q.size() != 0));
            chk("wr_ptr", wr_ptr, m_ofs);
            chk("evt_wrap", evt_wrap, m_wrap);
            chk("evt_eot", evt_eot, m_eot);
            chk("err", err, m_err);
            if (evt_wrap) wrap_cnt++;
            if (evt_eot)  eot_cnt++;
            m_wrap = 1'b0;
            m_eot  = 1'b0;
            if (cmd_clr) begin
                q.delete();
                m_ofs = '0; m_base = '0; m_size = '0;
                m_err = 1'b0; m_open = 1'b0;
            end else begin
                if (req && gnt && q.size() != 0) begin
                    e = q.pop_front();
                    if (e.sot) begin
                        m_base = e.base;
                        m_size = e.size;
                        cur    = '0;
                    end else begin
                        cur = m_ofs;
                    end
                    chk("wr_addr", addr, m_base + cur);
                    chk("wr_data", rdata, e.data);
                    chk("wr_dsize", rds, e.ds);
                    addr_log.push_back(addr);
                    nxt = {1'b0, cur} + ((e.ds == 2'd0) ? 17'd1 : (e.ds == 2'd1) ? 17'd2 : 17'd4);
                    if (m_size != 0 && nxt >= {1'b0, m_size}) begin
                        m_ofs  = '0;
                        m_wrap = 1'b1;
                    end else begin
                        m_ofs = nxt[15:0];
                    end
                    m_eot = e.eot;
                    if (e.ds == 2'd3) m_err = 1'b1;
                end
                if (svalid && ready) begin
                    if (ssot || m_open) begin
                        q.push_back('{sdata, sds, ssot, seot, cfg_start, cfg_size});
                        if (ssot && !m_open) m_ofs = '0;
                        m_open = !seot;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [1:0] d, input logic [31:0] dat, input logic [1:0] ds,
                        input logic sot, input logic eot);
        bit ok;
        ok = 1'b0;
        dest = d; sdata = dat; sds = ds; ssot = sot; seot = eot; svalid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = ready;
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: beat 0x%0h got no ready, expected ready within 100 cycles", dat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        svalid = 1'b0; ssot = 1'b0; seot = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clr();
        svalid = 1'b0; ssot = 1'b0; seot = 1'b0;
        cmd_clr = 1'b1;
        @(posedge clk);
        #1;
        cmd_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog");
    end

    int b;
    int w0;
    int e0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", req, 0);
        chk("rst_ready", ready, 0);
        chk("rst_wr_ptr", wr_ptr, 0);
        chk("rst_err", err, 0);
        chk("rst_evt_eot", evt_eot, 0);
        chk("rst_evt_wrap", evt_wrap, 0);
        chk("rst_addr", addr, 0);

        rstn = 1'b1;
        mon_en = 1'b1;
        cfg_en = 1'b1;
        cfg_start = 16'h0100;
        cfg_size = 16'h0040;
        gnt = 1'b1;
        idle(2);

        // Four 4-byte beats into a 64-byte window
        b = addr_log.size();
        send(2'd0, 32'hA000_0000, 2'd2, 1'b1, 1'b0);
        send(2'd0, 32'hA000_0001, 2'd2, 1'b0, 1'b0);
        send(2'd0, 32'hA000_0002, 2'd2, 1'b0, 1'b0);
        send(2'd0, 32'hA000_0003, 2'd2, 1'b0, 1'b1);
        idle(6);
        chk("t1_addr0", addr_log[b],   16'h0100);
        chk("t1_addr1", addr_log[b+1], 16'h0104);
        chk("t1_addr2", addr_log[b+2], 16'h0108);
        chk("t1_addr3", addr_log[b+3], 16'h010C);
        chk("t1_wr_ptr", wr_ptr, 16'h0010);

        // 8-byte window wraps after the second beat
        cfg_size = 16'h0008;
        b = addr_log.size();
        w0 = wrap_cnt;
        send(2'd0, 32'hB000_0000, 2'd2, 1'b1, 1'b0);
        send(2'd0, 32'hB000_0001, 2'd2, 1'b0, 1'b0);
        send(2'd0, 32'hB000_0002, 2'd2, 1'b0, 1'b1);
        idle(6);
        chk("t2_addr0", addr_log[b],   16'h0100);
        chk("t2_addr1", addr_log[b+1], 16'h0104);
        chk("t2_addr2", addr_log[b+2], 16'h0100);
        chk("t2_wrap_count", wrap_cnt - w0, 1);
        chk("t2_wr_ptr", wr_ptr, 16'h0004);

        // Grant withheld: buffer fills after two beats, then drains in order
        cfg_size = 16'h0040;
        gnt = 1'b0;
        b = addr_log.size();
        send(2'd0, 32'hC000_0000, 2'd2, 1'b1, 1'b0);
        send(2'd0, 32'hC000_0001, 2'd2, 1'b0, 1'b0);
        dest = 2'd0; sdata = 32'hC000_0002; sds = 2'd2; ssot = 1'b0; seot = 1'b0; svalid = 1'b1;
        repeat (3) @(negedge clk);
        chk("t3_ready_full", ready, 0);
        chk("t3_req_held", req, 1);
        @(posedge clk);
        #1;
        gnt = 1'b1;
        send(2'd0, 32'hC000_0002, 2'd2, 1'b0, 1'b0);
        send(2'd0, 32'hC000_0003, 2'd2, 1'b0, 1'b1);
        idle(8);
        chk("t3_writes", addr_log.size() - b, 4);
        chk("t3_addr3", addr_log[b+3], 16'h010C);
        chk("t3_wr_ptr", wr_ptr, 16'h0010);

        // Foreign destination is never accepted
        dest = 2'd1; sdata = 32'hDEAD_BEEF; sds = 2'd2; ssot = 1'b1; seot = 1'b0; svalid = 1'b1;
        repeat (4) @(negedge clk);
        chk("t4_ready_foreign", ready, 0);
        chk("t4_req_foreign", req, 0);
        @(posedge clk);
        #1;
        idle(1);
        // Non-SOT beat while armed: dropped and flagged
        send(2'd0, 32'hD000_0000, 2'd2, 1'b0, 1'b0);
        idle(3);
        chk("t4_err_stray", err, 1);
        chk("t4_req_stray", req, 0);
        pulse_clr();
        chk("t4_err_cleared", err, 0);
        idle(2);

        // Mixed 1B/2B/4B beats with EOT on the third
        cfg_start = 16'h0200;
        b = addr_log.size();
        e0 = eot_cnt;
        send(2'd0, 32'h0000_00E0, 2'd0, 1'b1, 1'b0);
        send(2'd0, 32'h0000_E1E1, 2'd1, 1'b0, 1'b0);
        send(2'd0, 32'hE2E2_E2E2, 2'd2, 1'b0, 1'b1);
        idle(8);
        chk("t5_addr0", addr_log[b],   16'h0200);
        chk("t5_addr1", addr_log[b+1], 16'h0201);
        chk("t5_addr2", addr_log[b+2], 16'h0203);
        chk("t5_wr_ptr", wr_ptr, 16'h0007);
        chk("t5_eot_count", eot_cnt - e0, 1);
        dest = 2'd0;
        chk("t5_rearmed_ready", ready, 1);

        // Illegal datasize advances 4 bytes and raises err
        send(2'd0, 32'hF000_0000, 2'd3, 1'b1, 1'b1);
        idle(6);
        chk("t6_wr_ptr", wr_ptr, 16'h0004);
        chk("t6_err", err, 1);

        // Clear with a full buffer mid-transfer
        send(2'd0, 32'h6000_0000, 2'd2, 1'b1, 1'b0);
        send(2'd0, 32'h6000_0001, 2'd2, 1'b0, 1'b0);
        svalid = 1'b0;
        idle(3);
        chk("t7_wr_ptr_pre", wr_ptr, 16'h0008);
        gnt = 1'b0;
        send(2'd0, 32'h6000_0002, 2'd2, 1'b0, 1'b0);
        send(2'd0, 32'h6000_0003, 2'd2, 1'b0, 1'b0);
        chk("t7_req_full", req, 1);
        pulse_clr();
        chk("t7_req_after_clr", req, 0);
        chk("t7_ready_after_clr", ready, 0);
        chk("t7_wr_ptr_after_clr", wr_ptr, 0);
        chk("t7_err_after_clr", err, 0);
        gnt = 1'b1;
        idle(4);
        chk("t7_req_no_leak", req, 0);
        dest = 2'd0;
        chk("t7_rearmed_ready", ready, 1);

        idle(2);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
